// File: rtl/seg_pkg.sv
// Shared constants and helpers for the segment scan path and its 3-bit decoder.
package seg_pkg;

  localparam int unsigned DIGIT_W        = 3;
  localparam int unsigned MAX_DIGITS     = 32;
  localparam int unsigned DEF_NUM_DIGITS = 8;
  localparam int unsigned DEF_DIV_CNT    = 50000;
  localparam int unsigned DEF_BLANK_CYC  = 4;

  // Low n bits set; callers cast the result down to their own digit count.
  function automatic logic [MAX_DIGITS-1:0] an_off(input int unsigned n);
    logic [MAX_DIGITS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) v[i] = (i < n);
    return v;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_mux_prescaler.sv
// Slot prescaler: counts 0..DIV_CNT-1 and flags the last cycle of every slot.
module scan_prescaler
  import seg_pkg::*;
#(
  parameter int unsigned DIV_CNT = DEF_DIV_CNT
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        tick_o,
  output logic [cnt_w(DIV_CNT)-1:0]   cnt_o
);

  localparam int unsigned CW = cnt_w(DIV_CNT);

  assign tick_o = (cnt_o == CW'(DIV_CNT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_o <= '0;
    end else if (tick_o) begin
      cnt_o <= '0;
    end else begin
      cnt_o <= cnt_o + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed digit scan driver feeding the 3-bit segment decoder.
// Optional ghost gap at the start of each slot: define SEG_SCAN_GHOST_GAP_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int unsigned DIV_CNT    = DEF_DIV_CNT,
  parameter int unsigned BLANK_CYC  = DEF_BLANK_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]         digit_en_i,
  output logic [DIGIT_W-1:0]            x_o,
  output logic                          blank_o,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic                          frame_done_o
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CW    = cnt_w(DIV_CNT);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = NUM_DIGITS'(an_off(NUM_DIGITS));

  logic                          tick;
  logic [CW-1:0]                 cnt;
  logic [IDX_W-1:0]              idx_q;
  logic                          last_slot;
  logic                          wrap;
  logic                          first_q;
  logic                          gap;
  logic [NUM_DIGITS*DIGIT_W-1:0] shadow_dig;
  logic [NUM_DIGITS-1:0]         shadow_en;

  scan_prescaler #(.DIV_CNT(DIV_CNT)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick),
    .cnt_o  (cnt)
  );

  assign last_slot = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign wrap      = tick && last_slot;

`ifdef SEG_SCAN_GHOST_GAP_EN
  // Signed compare keeps BLANK_CYC=0 legal without a constant-result compare.
  assign gap = (int'(cnt) < int'(BLANK_CYC));
`else
  assign gap = 1'b0;
  logic unused_gap;
  assign unused_gap = (^cnt) ^ (BLANK_CYC != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (tick) begin
      idx_q <= last_slot ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Shadow loads once right out of reset, then only at the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q    <= 1'b1;
      shadow_dig <= '0;
      shadow_en  <= '0;
    end else begin
      first_q <= 1'b0;
      if (first_q || wrap) begin
        shadow_dig <= digits_i;
        shadow_en  <= digit_en_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_o          <= '0;
      blank_o      <= 1'b1;
      an_o         <= AN_OFF;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= wrap;
      if (shadow_en[idx_q] && !gap) begin
        x_o     <= shadow_dig[idx_q*DIGIT_W +: DIGIT_W];
        blank_o <= 1'b0;
        an_o    <= ~(NUM_DIGITS'(1) << idx_q);
      end else begin
        x_o     <= '0;
        blank_o <= 1'b1;
        an_o    <= AN_OFF;
      end
    end
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Time-multiplexed scan driver placed directly upstream of the 3-bit-to-7-segment decoder. It holds a frame of NUM_DIGITS 3-bit digit values and walks through them at a prescaled rate. For each digit slot it drives the current digit value into the decoder's 3-bit input and asserts one active-low digit select. Digit values and enables are snapshotted once per frame, so the display never tears mid-frame.

Parameters:
NUM_DIGITS, 8, number of scanned digits; must be ≥2.
DIV_CNT, 50000, clk cycles per digit slot; must be ≥1.
BLANK_CYC, 4, dead cycles at the start of each slot (used only with the optional feature); must be < DIV_CNT.

Ports:
clk  in  1  system clock, single domain.
rst  in  1  synchronous, active-high reset.
digits_i  in  NUM_DIGITS*3  packed digit values; digit k is at bits [3k+2:3k].
digit_en_i  in  NUM_DIGITS  per-digit enable; 0 blanks that digit.
x_o  out  3  digit value fed to the decoder's x input.
blank_o  out  1  1 = current slot is blank; the integrator gates the segments off.
an_o  out  NUM_DIGITS  active-low digit select, one-cold or all-ones.
frame_done_o  out  1  one-cycle pulse on the last cycle of digit NUM_DIGITS-1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - div_cnt=0, idx=0, shadow digits=0, shadow enables=0.
  - Outputs: x_o=0, blank_o=1, an_o=all ones, frame_done_o=0.
- Prescaler:
  - div_cnt counts 0..DIV_CNT-1 and wraps to 0.
  - tick = (div_cnt==DIV_CNT-1). With DIV_CNT=1, tick is asserted every cycle.
- Slot index:
  - On tick, idx increments.
  - On tick with idx==NUM_DIGITS-1, idx wraps to 0. No out-of-range idx value is ever reachable.
- Snapshot:
  - The shadow registers load digits_i and digit_en_i on the cycle where idx wraps to 0.
  - They also load on the first cycle after rst deasserts.
  - Input changes at any other time have no effect until the next frame boundary.
- Output registers, updated every cycle from the current idx and shadow state (one-cycle latency):
  - Shadow enable[idx]=1: x_o=shadow[idx], blank_o=0, an_o=~(1<<idx).
  - Shadow enable[idx]=0: x_o=0, blank_o=1, an_o=all ones.
- frame_done_o = registered (tick && idx==NUM_DIGITS-1).
- Startup timing after rst deasserts at edge E:
  - The snapshot loads at E+1.
  - Outputs show digit 0 from E+2.
  - Each slot is exactly DIV_CNT cycles long; a frame is NUM_DIGITS*DIV_CNT cycles.
- rst asserted mid-slot: everything returns to reset values at that edge. No partial frame_done_o pulse is produced.
- All output registers are free of combinational paths from inputs.

Optional Feature:
Macro SEG_SCAN_GHOST_GAP_EN.
- Defined: for div_cnt < BLANK_CYC in every slot, outputs are forced to blank_o=1, an_o=all ones, x_o=0. This suppresses ghosting while the decoder settles. Slot length is unchanged.
- Undefined: no gap. BLANK_CYC is ignored and the gap logic is not synthesized.

Decomposition:
- Package seg_pkg: DIGIT_W=3, AN_OFF (all-ones helper function sized by NUM_DIGITS), and default constants for NUM_DIGITS and DIV_CNT. The decoder shares DIGIT_W.
- One sub-module, scan_prescaler: parameter DIV_CNT; ports clk, rst, tick_o, cnt_o. cnt_o is exposed for the ghost-gap comparison.
- The rest (index, shadow, output regs) stays flat.

Test Plan:
- Basic scan: NUM_DIGITS=4, DIV_CNT=4, digits_i={3'd3,3'd2,3'd1,3'd0}, all enables set, release rst. Expect:
  - x_o 0,1,2,3 repeating, each held 4 cycles.
  - an_o 1110,1101,1011,0111.
  - frame_done_o high exactly once per 16 cycles, on the last cycle of digit 3.
- Snapshot: change digits_i to all 3'd7 while idx=1 → x_o stays at the old values until frame end, then shows 7 on every digit.
- Blanking: digit_en_i=4'b1010 → slots 0 and 2 give blank_o=1 and an_o=1111; slots 1 and 3 are driven normally.
- Reset mid-slot: assert rst at idx=2, div_cnt=1 → next cycle an_o=1111, blank_o=1, no frame_done_o. Restart begins at digit 0 with a full 4-cycle slot.
- DIV_CNT=1 edge case: idx advances every cycle and frame_done_o pulses every 4 cycles; run 1000 cycles with no X on outputs.
- SEG_SCAN_GHOST_GAP_EN with BLANK_CYC=2, DIV_CNT=4: each slot shows 2 cycles of an_o=1111 then 2 driven cycles. Frame length stays 16 cycles.
